// File: rtl/ram_rw_checker_if.sv
// Control, status and RAM probe bundle of the RAM write/read-back checker.
// The checker takes the slave side; the board top or a bench takes the master side.
interface ram_rw_checker_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6,
   parameter int CNT_W  = 16
);
   logic              start;
   logic [DATA_W-1:0] seed;
   logic              invert;
   logic              continuous;
   logic              inj_en;
   logic [ADDR_W-1:0] inj_addr;

   logic              busy;
   logic              done;
   logic              pass;
   logic [CNT_W-1:0]  err_cnt;
   logic [ADDR_W-1:0] first_err_addr;

   logic              wr_en;
   logic              rd_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;

   modport master (
      output start, seed, invert, continuous, inj_en, inj_addr,
      input  busy, done, pass, err_cnt, first_err_addr,
      input  wr_en, rd_en, wr_addr, rd_addr, wr_data, rd_data
   );

   modport slave (
      input  start, seed, invert, continuous, inj_en, inj_addr,
      output busy, done, pass, err_cnt, first_err_addr,
      output wr_en, rd_en, wr_addr, rd_addr, wr_data, rd_data
   );
endinterface

// File: rtl/ram_rw_checker.sv
// Fills an inferred simple dual-port RAM with a seeded pattern, reads it back
// and reports pass/fail, a saturating error count and the first failing address.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | reset state, waiting for start
// S_WRITE | one pattern word written per cycle, addresses 0..DEPTH-1
// S_READ  | one read issued per cycle, addresses 0..DEPTH-1
// S_DRAIN | final compare of the last read word
// S_DONE  | results held; start or continuous begins another run
module ram_rw_checker #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6,
   parameter int CNT_W  = 16
) (
   input  logic           sys_clk,
   input  logic           sys_rst,
   ram_rw_checker_if.slave bus
);
   localparam int                DEPTH     = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
   localparam logic [DATA_W-1:0] LSB_MASK  = DATA_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic              busy, wr_en, rd_en, accept_start, rerun;
   logic [DATA_W-1:0] seed_q;
   logic              invert_q, inj_en_q;
   logic [ADDR_W-1:0] wr_addr_q, rd_addr_q, cmp_addr_q;
   logic [DATA_W-1:0] wr_word, exp_q, rd_data_q;
   logic              rd_en_q, done_q;
   logic [CNT_W-1:0]  err_cnt_q;
   logic [ADDR_W-1:0] first_err_addr_q;
   logic              mismatch;

   logic [DATA_W-1:0] mem [DEPTH];

   // Address is zero-extended or truncated to the word width before seeding.
   function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a,
                                             input logic [DATA_W-1:0] s,
                                             input logic              inv);
      logic [DATA_W+ADDR_W-1:0] wide;
      logic [DATA_W-1:0]        p;
      wide = {{DATA_W{1'b0}}, a};
      p    = wide[DATA_W-1:0] ^ s;
      return inv ? ~p : p;
   endfunction

   always_ff @(posedge sys_clk) begin
      if (sys_rst) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d      = state_q;
      busy         = 1'b0;
      wr_en        = 1'b0;
      rd_en        = 1'b0;
      accept_start = 1'b0;
      rerun        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               accept_start = 1'b1;
               state_d      = S_WRITE;
            end
         end
         S_WRITE: begin
            busy  = 1'b1;
            wr_en = 1'b1;
            if (wr_addr_q == LAST_ADDR) state_d = S_READ;
         end
         S_READ: begin
            busy  = 1'b1;
            rd_en = 1'b1;
            if (rd_addr_q == LAST_ADDR) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            busy    = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            // An explicit start overrides the automatic re-run.
            if (bus.start) begin
               accept_start = 1'b1;
               state_d      = S_WRITE;
            end else if (bus.continuous) begin
               rerun   = 1'b1;
               state_d = S_WRITE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_word = pat(wr_addr_q, seed_q, invert_q);
      if (inj_en_q && (wr_addr_q == bus.inj_addr)) wr_word = wr_word ^ LSB_MASK;
   end

   assign mismatch = rd_en_q && (rd_data_q != exp_q);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         seed_q           <= '0;
         invert_q         <= 1'b0;
         inj_en_q         <= 1'b0;
         wr_addr_q        <= '0;
         rd_addr_q        <= '0;
         rd_en_q          <= 1'b0;
         exp_q            <= '0;
         cmp_addr_q       <= '0;
         done_q           <= 1'b0;
         err_cnt_q        <= '0;
         first_err_addr_q <= '0;
      end else begin
         if (accept_start) begin
            seed_q   <= bus.seed;
            invert_q <= bus.invert;
            inj_en_q <= bus.inj_en;
         end else if (rerun) begin
            seed_q   <= seed_q + DATA_W'(1);
            invert_q <= bus.invert;
            inj_en_q <= bus.inj_en;
         end

         if (wr_en) wr_addr_q <= (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_W'(1);
         if (rd_en) rd_addr_q <= (rd_addr_q == LAST_ADDR) ? '0 : rd_addr_q + ADDR_W'(1);

         // Expected word and address follow the registered RAM read by one cycle.
         rd_en_q    <= rd_en;
         exp_q      <= pat(rd_addr_q, seed_q, invert_q);
         cmp_addr_q <= rd_addr_q;
         done_q     <= (state_q == S_DRAIN);

         if (accept_start || rerun) begin
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
         end else if (mismatch) begin
            if (err_cnt_q == '0)     first_err_addr_q <= cmp_addr_q;
            if (err_cnt_q != CNT_MAX) err_cnt_q       <= err_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge sys_clk) begin
      if (wr_en) mem[wr_addr_q] <= wr_word;
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst)    rd_data_q <= '0;
      else if (rd_en) rd_data_q <= mem[rd_addr_q];
   end

   assign bus.busy           = busy;
   assign bus.done           = done_q;
   assign bus.pass           = (state_q == S_DONE) && (err_cnt_q == '0);
   assign bus.err_cnt        = err_cnt_q;
   assign bus.first_err_addr = first_err_addr_q;
   assign bus.wr_en          = wr_en;
   assign bus.rd_en          = rd_en;
   assign bus.wr_addr        = wr_addr_q;
   assign bus.rd_addr        = rd_addr_q;
   assign bus.wr_data        = wr_en ? wr_word : '0;
   assign bus.rd_data        = rd_data_q;
endmodule

// File: tb/tb_ram_rw_checker.sv
// Bench for ram_rw_checker: a 64x8 instance driven from a run table with a
// read-back scoreboard, plus 4-deep and 2-deep instances for saturation and small depth.
module tb_ram_rw_checker;
   logic sys_clk = 1'b0;
   logic sys_rst = 1'b1;
   always #5 sys_clk = ~sys_clk;

   ram_rw_checker_if #(.DATA_W(8), .ADDR_W(6), .CNT_W(16)) b0 ();
   ram_rw_checker_if #(.DATA_W(8), .ADDR_W(2), .CNT_W(2))  b1 ();
   ram_rw_checker_if #(.DATA_W(4), .ADDR_W(1), .CNT_W(16)) b2 ();

   ram_rw_checker #(.DATA_W(8), .ADDR_W(6), .CNT_W(16)) u_main (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(b0));
   ram_rw_checker #(.DATA_W(8), .ADDR_W(2), .CNT_W(2)) u_sat (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(b1));
   ram_rw_checker #(.DATA_W(4), .ADDR_W(1), .CNT_W(16)) u_d2 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .bus(b2));

   // The two small instances share one set of stimulus variables.
   logic       s_start, s_inv, s_inj_en;
   logic [7:0] s_seed;
   logic [1:0] s_inj_addr;
   assign b1.start      = s_start;
   assign b1.seed       = s_seed;
   assign b1.invert     = s_inv;
   assign b1.continuous = 1'b0;
   assign b1.inj_en     = s_inj_en;
   assign b1.inj_addr   = s_inj_addr;
   assign b2.start      = s_start;
   assign b2.seed       = s_seed[3:0];
   assign b2.invert     = s_inv;
   assign b2.continuous = 1'b0;
   assign b2.inj_en     = s_inj_en;
   assign b2.inj_addr   = s_inj_addr[0];

   typedef struct {
      logic [7:0]  seed;
      logic        inv;
      logic        inj;
      logic [5:0]  inj_addr;
      logic        exp_pass;
      logic [15:0] exp_err;
      logic [5:0]  exp_first;
   } vec_t;

   vec_t       vecs[5];
   logic [7:0] wq[$];
   logic [7:0] rq[$];
   int         n_cmp = 0;
   int         n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] pat_m(input int a, input logic [7:0] s, input logic inv);
      logic [7:0] p;
      p = 8'(a) ^ s;
      return inv ? ~p : p;
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},    32'(b0.busy), 0);
      chk({tag, "_done"},    32'(b0.done), 0);
      chk({tag, "_pass"},    32'(b0.pass), 0);
      chk({tag, "_err_cnt"}, 32'(b0.err_cnt), 0);
      chk({tag, "_first"},   32'(b0.first_err_addr), 0);
      chk({tag, "_wr_en"},   32'(b0.wr_en), 0);
      chk({tag, "_rd_en"},   32'(b0.rd_en), 0);
      chk({tag, "_wr_addr"}, 32'(b0.wr_addr), 0);
      chk({tag, "_rd_addr"}, 32'(b0.rd_addr), 0);
      chk({tag, "_wr_data"}, 32'(b0.wr_data), 0);
      chk({tag, "_rd_data"}, 32'(b0.rd_data), 0);
   endtask

   // Called at a falling edge with the main instance in IDLE or DONE.
   task automatic run_main(input vec_t v);
      int         done_cyc;
      logic [7:0] e;
      done_cyc = -1;
      wq.delete();
      rq.delete();
      for (int a = 0; a < 64; a++) begin
         e = pat_m(a, v.seed, v.inv);
         if (v.inj && (6'(a) == v.inj_addr)) e[0] = ~e[0];
         wq.push_back(e);
         rq.push_back(e);
      end
      b0.seed     = v.seed;
      b0.invert   = v.inv;
      b0.inj_en   = v.inj;
      b0.inj_addr = v.inj_addr;
      b0.start    = 1'b1;
      for (int c = 1; c <= 140 && done_cyc < 0; c++) begin
         @(negedge sys_clk);
         b0.start = 1'b0;
         if (c <= 64) begin
            chk("wr_addr", 32'(b0.wr_addr), 32'(c - 1));
            chk("wr_data", 32'(b0.wr_data), 32'(wq.pop_front()));
         end
         if (c == 65) chk("rd_en_first", 32'(b0.rd_en), 1);
         if (c >= 66 && c <= 129) chk("rd_data", 32'(b0.rd_data), 32'(rq.pop_front()));
         if (c == 1 || c == 129) chk("busy", 32'(b0.busy), 1);
         if (b0.done) done_cyc = c;
      end
      chk("done_cycle", 32'(done_cyc), 130);
      chk("pass",       32'(b0.pass), 32'(v.exp_pass));
      chk("err_cnt",    32'(b0.err_cnt), 32'(v.exp_err));
      chk("first_err",  32'(b0.first_err_addr), 32'(v.exp_first));
      chk("busy_done",  32'(b0.busy), 0);
      @(negedge sys_clk);
      chk("done_pulse_width", 32'(b0.done), 0);
   endtask

   int ndone, dc0, dc1, d1c, d2c;
   int sat_exp[5];

   initial begin
      vecs[0] = '{8'h00, 1'b0, 1'b0, 6'h00, 1'b1, 16'd0, 6'h00};
      vecs[1] = '{8'hA5, 1'b1, 1'b0, 6'h00, 1'b1, 16'd0, 6'h00};
      vecs[2] = '{8'h00, 1'b0, 1'b1, 6'h2A, 1'b0, 16'd1, 6'h2A};
      vecs[3] = '{8'h3C, 1'b1, 1'b1, 6'h3F, 1'b0, 16'd1, 6'h3F};
      vecs[4] = '{8'h7E, 1'b0, 1'b1, 6'h00, 1'b0, 16'd1, 6'h00};
      sat_exp = '{0, 1, 2, 3, 3};

      b0.start = 1'b0; b0.seed = '0; b0.invert = 1'b0; b0.continuous = 1'b0;
      b0.inj_en = 1'b0; b0.inj_addr = '0;
      s_start = 1'b0; s_seed = '0; s_inv = 1'b0; s_inj_en = 1'b0; s_inj_addr = '0;

      repeat (3) @(negedge sys_clk);
      chk_all_zero("reset");
      sys_rst = 1'b0;
      @(negedge sys_clk);
      chk("idle_busy", 32'(b0.busy), 0);

      for (int i = 0; i < 5; i++) run_main(vecs[i]);

      // Continuous mode: seed FF then FF+1 = 00; a start while busy is ignored.
      rq.delete();
      for (int k = 0; k < 64; k++) rq.push_back(pat_m(k, 8'hFF, 1'b0));
      for (int k = 0; k < 64; k++) rq.push_back(pat_m(k, 8'h00, 1'b0));
      b0.seed = 8'hFF; b0.invert = 1'b0; b0.inj_en = 1'b0; b0.continuous = 1'b1;
      b0.start = 1'b1;
      ndone = 0; dc0 = -1; dc1 = -1;
      for (int c = 1; c <= 262; c++) begin
         @(negedge sys_clk);
         b0.start = (c == 50);
         if (c == 50) b0.seed = 8'h11;
         if ((c >= 66 && c <= 129) || (c >= 196 && c <= 259))
            chk("cont_rd_data", 32'(b0.rd_data), 32'(rq.pop_front()));
         if (b0.done) begin
            ndone++;
            if (ndone == 1) dc0 = c;
            else if (ndone == 2) dc1 = c;
            chk("cont_pass", 32'(b0.pass), 1);
         end
         if (c == 260) b0.continuous = 1'b0;
      end
      chk("cont_done_count", 32'(ndone), 2);
      chk("cont_done1_cycle", 32'(dc0), 130);
      chk("cont_done2_cycle", 32'(dc1), 260);
      chk("cont_stopped", 32'(b0.busy), 0);

      // Reset during READ, after one injected error is already counted.
      b0.seed = 8'h12; b0.inj_en = 1'b1; b0.inj_addr = 6'h05; b0.start = 1'b1;
      for (int c = 1; c <= 80; c++) begin
         @(negedge sys_clk);
         b0.start = 1'b0;
      end
      chk("pre_rst_err_cnt", 32'(b0.err_cnt), 1);
      chk("pre_rst_rd_en", 32'(b0.rd_en), 1);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      chk_all_zero("midrst");
      sys_rst = 1'b0;
      b0.inj_en = 1'b0;
      ndone = 0;
      repeat (200) begin
         @(negedge sys_clk);
         if (b0.done) ndone++;
      end
      chk("rst_no_done", 32'(ndone), 0);
      run_main(vecs[0]);

      // Saturation: inj_addr tracks the write address so every word is corrupted.
      s_seed = 8'h00; s_inv = 1'b0; s_inj_en = 1'b1; s_inj_addr = 2'd0; s_start = 1'b1;
      d1c = -1; d2c = -1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge sys_clk);
         s_start = 1'b0;
         if (c <= 4) s_inj_addr = 2'(c - 1);
         if (c >= 6 && c <= 10) chk("sat_err_cnt", 32'(b1.err_cnt), 32'(sat_exp[c - 6]));
         if (b1.done && d1c < 0) begin
            d1c = c;
            chk("sat_pass", 32'(b1.pass), 0);
            chk("sat_first", 32'(b1.first_err_addr), 0);
         end
         if (b2.done && d2c < 0) begin
            d2c = c;
            chk("d2_err_cnt", 32'(b2.err_cnt), 2);
            chk("d2_first", 32'(b2.first_err_addr), 0);
            chk("d2_pass", 32'(b2.pass), 0);
         end
      end
      chk("sat_done_cycle", 32'(d1c), 10);
      chk("d2_done_cycle", 32'(d2c), 6);

      // Clean inverted runs on both small instances; counters must clear.
      s_inj_en = 1'b0; s_seed = 8'h5A; s_inv = 1'b1; s_start = 1'b1;
      d1c = -1; d2c = -1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge sys_clk);
         s_start = 1'b0;
         if (c == 1) chk("sat_cleared", 32'(b1.err_cnt), 0);
         if (c >= 6 && c <= 9) chk("d4_rd_data", 32'(b1.rd_data), 32'(pat_m(c - 6, 8'h5A, 1'b1)));
         if (c >= 4 && c <= 5) chk("d2_rd_data", 32'(b2.rd_data), 32'(pat_m(c - 4, 8'h5A, 1'b1) & 8'h0F));
         if (b1.done && d1c < 0) begin
            d1c = c;
            chk("d4_clean_pass", 32'(b1.pass), 1);
         end
         if (b2.done && d2c < 0) begin
            d2c = c;
            chk("d2_clean_pass", 32'(b2.pass), 1);
            chk("d2_clean_err", 32'(b2.err_cnt), 0);
         end
      end
      chk("d4_clean_done_cycle", 32'(d1c), 10);
      chk("d2_clean_done_cycle", 32'(d2c), 6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
